// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-port round-robin arbiter driving a single-port RAM block
module ram_port_arbiter #(
    parameter int N   = 8,
    parameter int A_N = 7
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           req0,
    input  logic           req1,
    input  logic           we0,
    input  logic           we1,
    input  logic [A_N-1:0] addr0,
    input  logic [A_N-1:0] addr1,
    input  logic [N-1:0]   wdata0,
    input  logic [N-1:0]   wdata1,
    output logic           ack0,
    output logic           ack1,
    output logic [N-1:0]   rdata0,
    output logic [N-1:0]   rdata1,
    output logic           rvalid0,
    output logic           rvalid1,
    output logic [A_N-1:0] ram_addr_r,
    output logic [A_N-1:0] ram_addr_w,
    output logic [N-1:0]   ram_data_i,
    output logic           ram_wr,
    output logic           ram_a_rd,
    output logic           ram_oe,
    input  logic [N-1:0]   ram_data_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WRITE   = 2'd1;
    localparam logic [1:0] ST_READ    = 2'd2;
    localparam logic [1:0] ST_CAPTURE = 2'd3;

    logic [1:0]     state;
    logic           last_gnt;
    logic           cur_port;

    logic           req_any;
    logic           win;
    logic           win_we;
    logic [A_N-1:0] win_addr;
    logic [N-1:0]   win_wdata;

    // Pick the winner: a lone requester wins, on a tie the port not served last wins.
    always_comb begin
        req_any   = req0 | req1;
        win       = (req0 & req1) ? ~last_gnt : req1;
        win_we    = win ? we1 : we0;
        win_addr  = win ? addr1 : addr0;
        win_wdata = win ? wdata1 : wdata0;
    end

    // Access sequencer; every RAM pin and handshake output comes straight from a flop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            last_gnt   <= 1'b1;
            cur_port   <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            ram_addr_r <= '0;
            ram_addr_w <= '0;
            ram_data_i <= '0;
            ram_wr     <= 1'b0;
            ram_a_rd   <= 1'b0;
            ram_oe     <= 1'b1;
        end else begin
            ram_oe  <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        last_gnt <= win;
                        cur_port <= win;
                        ack0     <= ~win;
                        ack1     <= win;
                        if (win_we) begin
                            ram_wr     <= 1'b1;
                            ram_addr_w <= win_addr;
                            ram_data_i <= win_wdata;
                            state      <= ST_WRITE;
                        end else begin
                            ram_a_rd   <= 1'b1;
                            ram_addr_r <= win_addr;
                            state      <= ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    ram_wr <= 1'b0;
                    state  <= ST_IDLE;
                end
                ST_READ: begin
                    ram_a_rd <= 1'b0;
                    state    <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (cur_port) begin
                        rdata1  <= ram_data_o;
                        rvalid1 <= 1'b1;
                    end else begin
                        rdata0  <= ram_data_o;
                        rvalid0 <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    ram_wr   <= 1'b0;
                    ram_a_rd <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       we0 = 1'b0, we1 = 1'b0;
    logic [6:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       ack0, ack1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic [6:0] ram_addr_r, ram_addr_w;
    logic [7:0] ram_data_i, ram_data_o;
    logic       ram_wr, ram_a_rd, ram_oe;

    int n_checks = 0;
    int n_errors = 0;
    int n_ack0 = 0, n_wr = 0, n_ard = 0;

    logic [7:0] mem [128];
    logic [7:0] ram_q = 8'h00;

    ram_port_arbiter #(.N(8), .A_N(7)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .ram_addr_r(ram_addr_r), .ram_addr_w(ram_addr_w), .ram_data_i(ram_data_i),
        .ram_wr(ram_wr), .ram_a_rd(ram_a_rd), .ram_oe(ram_oe), .ram_data_o(ram_data_o)
    );

    always #5 CLK = ~CLK;

    // RAM block model: write commits and read loads at the clock edge
    initial for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    always @(posedge CLK) begin
        if (ram_wr) mem[ram_addr_w] <= ram_data_i;
        if (ram_a_rd) ram_q <= mem[ram_addr_r];
    end
    assign ram_data_o = ram_q;

    // activity counters sampled mid-cycle
    always @(negedge CLK) begin
        if (ack0) n_ack0++;
        if (ram_wr) n_wr++;
        if (ram_a_rd) n_ard++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, {30'd0, ack1, ack0}, 32'd0);
        check({tag, "_rvalid"}, {30'd0, rvalid1, rvalid0}, 32'd0);
        check({tag, "_rdata"}, {16'd0, rdata1, rdata0}, 32'd0);
        check({tag, "_wr_ard"}, {30'd0, ram_wr, ram_a_rd}, 32'd0);
        check({tag, "_addr_data"}, {10'd0, ram_addr_r, ram_addr_w, ram_data_i}, 32'd0);
        check({tag, "_oe"}, {31'd0, ram_oe}, 32'd1);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    task automatic access(input int port, input logic we, input logic [6:0] a,
                          input logic [7:0] d, output logic [7:0] q);
        logic got;
        got = 1'b0;
        q = 8'h00;
        if (port == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        else           begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = (port == 0) ? ack0 : ack1;
        end
        check("ack_seen", {31'd0, got}, 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        if (!we) begin
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                tick();
                got = (port == 0) ? rvalid0 : rvalid1;
            end
            check("rvalid_seen", {31'd0, got}, 32'd1);
            q = (port == 0) ? rdata0 : rdata1;
        end else begin
            tick();
        end
    endtask

    logic [7:0] q;
    int         grants [4];
    int         ng;
    int         s_ack0, s_wr, s_ard;

    initial begin
        // reset state
        RST_N = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        RST_N = 1'b1;
        #1;
        check("oe_before_edge", {31'd0, ram_oe}, 32'd1);

        // 1: write A5 to 05, exact cycle timing
        req0 = 1'b1; we0 = 1'b1; addr0 = 7'h05; wdata0 = 8'hA5;
        tick();
        check("t1_ack", {30'd0, ack1, ack0}, 32'd1);
        check("t1_wr", {31'd0, ram_wr}, 32'd1);
        check("t1_addr_w", {25'd0, ram_addr_w}, 32'h05);
        check("t1_data_i", {24'd0, ram_data_i}, 32'hA5);
        check("t1_oe", {31'd0, ram_oe}, 32'd0);
        req0 = 1'b0;
        tick();
        check("t1_ack_end", {30'd0, ack1, ack0}, 32'd0);
        check("t1_wr_end", {31'd0, ram_wr}, 32'd0);

        // 2: port 1 reads 05, data valid two edges after the grant
        req1 = 1'b1; we1 = 1'b0; addr1 = 7'h05;
        tick();
        check("t2_ack", {30'd0, ack1, ack0}, 32'd2);
        check("t2_ard", {31'd0, ram_a_rd}, 32'd1);
        check("t2_addr_r", {25'd0, ram_addr_r}, 32'h05);
        req1 = 1'b0;
        tick();
        check("t2_ard_end", {31'd0, ram_a_rd}, 32'd0);
        check("t2_rvalid_early", {30'd0, rvalid1, rvalid0}, 32'd0);
        tick();
        check("t2_rvalid", {30'd0, rvalid1, rvalid0}, 32'd2);
        check("t2_rdata", {24'd0, rdata1}, 32'hA5);
        tick();
        check("t2_rvalid_end", {30'd0, rvalid1, rvalid0}, 32'd0);
        check("t2_rdata_hold", {24'd0, rdata1}, 32'hA5);

        // 4: top address
        access(0, 1'b1, 7'h7F, 8'h3C, q);
        access(1, 1'b0, 7'h7F, 8'h00, q);
        check("t4_read_7f_p1", {24'd0, q}, 32'h3C);
        access(0, 1'b0, 7'h7F, 8'h00, q);
        check("t4_read_7f_p0", {24'd0, q}, 32'h3C);

        // 3: both ports held with reads -> alternating grants starting at port 0
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 7'h05;
        req1 = 1'b1; we1 = 1'b0; addr1 = 7'h7F;
        ng = 0;
        for (int i = 0; i < 30 && ng < 4; i++) begin
            tick();
            if (ack0) begin grants[ng] = 0; ng++; end
            else if (ack1) begin grants[ng] = 1; ng++; end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("t3_grant_count", ng, 4);
        for (int i = 0; i < 4; i++)
            if (i < ng) check($sformatf("t3_grant%0d", i), grants[i], i % 2);
        repeat (4) tick();
        check("t3_rdata0", {24'd0, rdata0}, 32'hA5);
        check("t3_rdata1", {24'd0, rdata1}, 32'h3C);

        // 5: reset during write aborts it
        req0 = 1'b1; we0 = 1'b1; addr0 = 7'h05; wdata0 = 8'h99;
        tick();
        check("t5_wr", {31'd0, ram_wr}, 32'd1);
        req0 = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        tick();
        RST_N = 1'b1;
        #1;
        check("t5_oe_held", {31'd0, ram_oe}, 32'd1);
        tick();
        check("t5_oe_low", {31'd0, ram_oe}, 32'd0);
        access(1, 1'b0, 7'h05, 8'h00, q);
        check("t5_prior_data", {24'd0, q}, 32'hA5);

        // 6: short req0 pulse during a port 1 read is ignored
        s_ack0 = n_ack0; s_wr = n_wr; s_ard = n_ard;
        req1 = 1'b1; we1 = 1'b0; addr1 = 7'h7F;
        tick();
        check("t6_ack1", {31'd0, ack1}, 32'd1);
        req1 = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 7'h10; wdata0 = 8'h55;
        tick();
        req0 = 1'b0;
        repeat (5) tick();
        check("t6_no_ack0", n_ack0 - s_ack0, 0);
        check("t6_no_write", n_wr - s_wr, 0);
        check("t6_one_read", n_ard - s_ard, 1);
        check("t6_rdata1", {24'd0, rdata1}, 32'h3C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
